// File: rtl/lime_mem_pkg.sv
// Shared types and constants for the memory access stage.
package lime_mem_pkg;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DEST_MDR = 1'b0;
    localparam logic DEST_IR  = 1'b1;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter; expire flags the cycle whose count equals TIMEOUT.
module mem_timeout_ctr #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    assign expire = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_access_unit.sv
// Memory-side stage: converts control strobes into a req/ack memory transaction,
// owns IR and MDR, and stalls the control FSM until the access completes.
module mem_access_unit
    import lime_mem_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              MemR,
    input  logic              MemW,
    input  logic              IRWrite,
    input  logic              IoD,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] ir_out,
    output logic [6:0]        ctrl_bits,
    output logic [DATA_W-1:0] mdr_out,
    output logic              stall,
    output logic              err
);

    state_t state, state_next;
    logic   cmd;
    logic   dest;
    logic   cnt_clr, cnt_en, expire;

    assign cmd       = MemR | MemW | IRWrite;
    assign ctrl_bits = ir_out[6:0];

    // Counting starts on the accepting IDLE edge so WAIT cycle k sees count == k.
    mem_timeout_ctr #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (CLK),
        .rst_n  (Reset_n),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .expire (expire)
    );

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            IDLE: begin
                stall = cmd;
                if (cmd) begin
                    cnt_en     = 1'b1;
                    state_next = WAIT;
                end else begin
                    cnt_clr = 1'b1;
                end
            end
            WAIT: begin
                stall  = 1'b1;
                cnt_en = 1'b1;
                if (mem_ack || expire)
                    state_next = DONE;
            end
            DONE: begin
                cnt_clr    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                cnt_clr    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            dest      <= DEST_MDR;
            ir_out    <= '0;
            mdr_out   <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemW;
                        mem_addr  <= IoD ? alu_out : pc_addr;
                        mem_wdata <= wdata;
                        dest      <= IRWrite ? DEST_IR : DEST_MDR;
                        // Write wins an illegal read/write mix; the conflict is flagged.
                        if (MemW && (MemR || IRWrite))
                            err <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            if (dest == DEST_IR)
                                ir_out <= mem_rdata;
                            else
                                mdr_out <= mem_rdata;
                        end
                    end else if (expire) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
